// File: rtl/sb_drain_unit.sv
// Store-buffer drain unit: takes committed stores into a hold register and issues memory writes.
// Build option `SB_DRAIN_MERGE_EN merges same-word stores into the pending hold entry.
module sb_drain_unit #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sb_valid_i,
    output logic                sb_ready_o,
    input  logic [ADDR_W-1:0]   sb_addr_i,
    input  logic [DATA_W-1:0]   sb_data_i,
    input  logic [DATA_W/8-1:0] sb_strb_i,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_req_addr_o,
    output logic [DATA_W-1:0]   mem_req_data_o,
    output logic [DATA_W/8-1:0] mem_req_strb_o,
    input  logic                mem_resp_valid_i,
    input  logic                mem_resp_err_i,
    output logic                mem_resp_ready_o,
    output logic                drained_o,
    output logic                bus_err_o
);
    localparam int unsigned       STRB_W   = DATA_W / 8;
    localparam logic [CNT_W-1:0]  MaxCnt   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [ADDR_W-1:0] AddrMask = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StStall = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic                hold_valid_q, hold_valid_d;
    logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0]   hold_data_q, hold_data_d;
    logic [STRB_W-1:0]   hold_strb_q, hold_strb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                bus_err_q, bus_err_d;
    logic                drained_q, drained_d;

    logic req_fire;
    logic resp_fire;
    logic resp_stray;
    logic cnt_dec;
    logic merge_hit;
    logic sb_accept;
    logic load_new;

    assign mem_req_valid_o  = (state_q == StIssue);
    assign mem_req_addr_o   = hold_addr_q;
    assign mem_req_data_o   = hold_data_q;
    assign mem_req_strb_o   = hold_strb_q;
    assign mem_resp_ready_o = 1'b1;
    assign drained_o        = drained_q;
    assign bus_err_o        = bus_err_q;

    assign req_fire   = mem_req_valid_o & mem_req_ready_i;
    assign resp_fire  = mem_resp_valid_i;
    // A response with nothing outstanding is dropped and flagged as a bus error.
    assign resp_stray = resp_fire & (cnt_q == '0);
    assign cnt_dec    = resp_fire & ~resp_stray;

`ifdef SB_DRAIN_MERGE_EN
    logic [DATA_W-1:0] merged_data;

    // Merge only into a hold entry that is not leaving this cycle.
    assign merge_hit = hold_valid_q & ~req_fire & ((sb_addr_i & AddrMask) == hold_addr_q);

    always_comb begin
        merged_data = hold_data_q;
        for (int i = 0; i < STRB_W; i++) begin
            if (sb_strb_i[i]) begin
                merged_data[8*i +: 8] = sb_data_i[8*i +: 8];
            end
        end
    end
`else
    assign merge_hit = 1'b0;
`endif

    assign sb_ready_o = ~hold_valid_q | req_fire | merge_hit;
    assign sb_accept  = sb_valid_i & sb_ready_o;
    assign load_new   = sb_accept & ~merge_hit;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        hold_strb_d  = hold_strb_q;
        if (req_fire) begin
            hold_valid_d = 1'b0;
        end
        if (load_new) begin
            hold_valid_d = 1'b1;
            hold_addr_d  = sb_addr_i & AddrMask;
            hold_data_d  = sb_data_i;
            hold_strb_d  = sb_strb_i;
        end
`ifdef SB_DRAIN_MERGE_EN
        else if (sb_accept) begin
            hold_data_d = merged_data;
            hold_strb_d = hold_strb_q | sb_strb_i;
        end
`endif
    end

    always_comb begin
        cnt_d = cnt_q;
        if (req_fire && !cnt_dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!req_fire && cnt_dec) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // State tracks the next hold/counter values so the request valid is a pure flop output.
    always_comb begin
        if (!hold_valid_d) begin
            state_d = StIdle;
        end else if (cnt_d < MaxCnt) begin
            state_d = StIssue;
        end else begin
            state_d = StStall;
        end
        bus_err_d = bus_err_q | (resp_fire & mem_resp_err_i) | resp_stray;
        drained_d = ~hold_valid_d & (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            hold_strb_q  <= '0;
            cnt_q        <= '0;
            bus_err_q    <= 1'b0;
            drained_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            hold_strb_q  <= hold_strb_d;
            cnt_q        <= cnt_d;
            bus_err_q    <= bus_err_d;
            drained_q    <= drained_d;
        end
    end

`ifndef SYNTHESIS
    cnt_bound_a: assert property (@(posedge clk) disable iff (rst) cnt_q <= MaxCnt);
`ifndef SB_DRAIN_MERGE_EN
    req_stable_a: assert property (@(posedge clk) disable iff (rst)
        (mem_req_valid_o && !mem_req_ready_i) |=>
        (mem_req_valid_o && $stable(mem_req_addr_o) && $stable(mem_req_data_o)
         && $stable(mem_req_strb_o)));
`endif
`endif

endmodule

// File: tb/tb_sb_drain_unit.sv
// Bench for sb_drain_unit: directed scenarios plus random traffic against a transaction-level model.
module tb_sb_drain_unit;
    localparam int MAX_OUT = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sb_valid_i = 1'b0;
    logic        sb_ready_o;
    logic [31:0] sb_addr_i = '0;
    logic [31:0] sb_data_i = '0;
    logic [3:0]  sb_strb_i = '0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic [31:0] mem_req_addr_o;
    logic [31:0] mem_req_data_o;
    logic [3:0]  mem_req_strb_o;
    logic        mem_resp_valid_i = 1'b0;
    logic        mem_resp_err_i = 1'b0;
    logic        mem_resp_ready_o;
    logic        drained_o;
    logic        bus_err_o;

    sb_drain_unit dut (
        .clk              (clk),
        .rst              (rst),
        .sb_valid_i       (sb_valid_i),
        .sb_ready_o       (sb_ready_o),
        .sb_addr_i        (sb_addr_i),
        .sb_data_i        (sb_data_i),
        .sb_strb_i        (sb_strb_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_data_o   (mem_req_data_o),
        .mem_req_strb_o   (mem_req_strb_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_err_i   (mem_resp_err_i),
        .mem_resp_ready_o (mem_resp_ready_o),
        .drained_o        (drained_o),
        .bus_err_o        (bus_err_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Model: stores accepted but not yet issued, writes issued but unanswered, sticky error.
    ent_t mq[$];
    int   m_out = 0;
    bit   m_err = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Entered and left at a falling edge; one call covers one rising edge.
    task automatic step(input logic sv, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic rr, input logic rv, input logic re);
        bit   exp_valid;
        bit   fire;
        bit   hit;
        bit   exp_ready;
        ent_t e;
        logic [31:0] mask;
        exp_valid = (mq.size() > 0) && (m_out < MAX_OUT);
        check_eq("req_valid", 32'(mem_req_valid_o), 32'(exp_valid));
        check_eq("drained", 32'(drained_o), 32'((mq.size() == 0) && (m_out == 0)));
        check_eq("bus_err", 32'(bus_err_o), 32'(m_err));
        check_eq("resp_ready", 32'(mem_resp_ready_o), 32'd1);
        if (exp_valid) begin
            check_eq("req_addr", mem_req_addr_o, mq[0].addr & 32'hFFFF_FFFC);
            check_eq("req_data", mem_req_data_o, mq[0].data);
            check_eq("req_strb", 32'(mem_req_strb_o), 32'(mq[0].strb));
        end
        sb_valid_i       = sv;
        sb_addr_i        = a;
        sb_data_i        = d;
        sb_strb_i        = s;
        mem_req_ready_i  = rr;
        mem_resp_valid_i = rv;
        mem_resp_err_i   = re;
        #1;
        fire = exp_valid && rr;
        hit  = 1'b0;
`ifdef SB_DRAIN_MERGE_EN
        hit = (mq.size() > 0) && !fire && (a[31:2] == mq[0].addr[31:2]);
`endif
        exp_ready = (mq.size() == 0) || fire || hit;
        check_eq("sb_ready", 32'(sb_ready_o), 32'(exp_ready));
        if (rv) begin
            if (m_out == 0) m_err = 1'b1;
            else m_out--;
            if (re) m_err = 1'b1;
        end
        if (fire) begin
            void'(mq.pop_front());
            m_out++;
        end
        if (sv && exp_ready) begin
            if (hit) begin
                mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
                e = mq[0];
                e.data = (e.data & ~mask) | (d & mask);
                e.strb = e.strb | s;
                mq[0] = e;
            end else begin
                e.addr = a;
                e.data = d;
                e.strb = s;
                mq.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rr, input logic rv);
        step(1'b0, 32'h0, 32'h0, 4'h0, rr, rv, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb_valid_i = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_err_i = 1'b0;
        mq.delete();
        m_out = 0;
        m_err = 1'b0;
        #1;
        check_eq("rst_drained", 32'(drained_o), 32'd1);
        check_eq("rst_sb_ready", 32'(sb_ready_o), 32'd1);
        check_eq("rst_req_valid", 32'(mem_req_valid_o), 32'd0);
        check_eq("rst_bus_err", 32'(bus_err_o), 32'd0);
        check_eq("rst_addr", mem_req_addr_o, 32'h0);
        check_eq("rst_data", mem_req_data_o, 32'h0);
        check_eq("rst_strb", 32'(mem_req_strb_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && !((mq.size() == 0) && (m_out == 0)); i++) begin
            idle(1'b1, m_out > 0);
        end
        check_eq(tag, 32'(drained_o), 32'd1);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);

        // Single store, response three cycles after issue.
        step(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 1'b0);
        check_eq("t2_valid", 32'(mem_req_valid_o), 32'd1);
        check_eq("t2_addr", mem_req_addr_o, 32'h1000_0004);
        check_eq("t2_data", mem_req_data_o, 32'hDEAD_BEEF);
        check_eq("t2_strb", 32'(mem_req_strb_o), 32'hF);
        check_eq("t2_drained_lo", 32'(drained_o), 32'd0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check_eq("t2_wait_drained", 32'(drained_o), 32'd0);
        idle(1'b1, 1'b1);
        check_eq("t2_drained", 32'(drained_o), 32'd1);

        // Three back-to-back stores with responses withheld.
        step(1'b1, 32'h0000_0100, 32'h0000_0001, 4'hF, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0104, 32'h0000_0002, 4'hF, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0108, 32'h0000_0003, 4'hF, 1'b1, 1'b0, 1'b0);
        check_eq("t3_stall_valid", 32'(mem_req_valid_o), 32'd0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check_eq("t3_still_stall", 32'(mem_req_valid_o), 32'd0);
        idle(1'b1, 1'b1);
        check_eq("t3_release_valid", 32'(mem_req_valid_o), 32'd1);
        check_eq("t3_release_addr", mem_req_addr_o, 32'h0000_0108);
        drain("t3_drained");

        // Back-pressure: hold stays, then pass-through accept on ready.
        step(1'b1, 32'h0000_4000, 32'hCAFE_0001, 4'hF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h0000_4010, 32'hCAFE_0002, 4'hF, 1'b0, 1'b0, 1'b0);
        end
        check_eq("t4_hold_addr", mem_req_addr_o, 32'h0000_4000);
        check_eq("t4_hold_data", mem_req_data_o, 32'hCAFE_0001);
        step(1'b1, 32'h0000_4010, 32'hCAFE_0002, 4'hF, 1'b1, 1'b0, 1'b0);
        check_eq("t4_pass_addr", mem_req_addr_o, 32'h0000_4010);
        check_eq("t4_pass_data", mem_req_data_o, 32'hCAFE_0002);
        drain("t4_drained");

        // Error response is sticky.
        step(1'b1, 32'h0000_5000, 32'h0000_5555, 4'h1, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1);
        check_eq("t5_err_set", 32'(bus_err_o), 32'd1);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check_eq("t5_err_sticky", 32'(bus_err_o), 32'd1);
        do_reset();

        // Stray response with nothing outstanding.
        idle(1'b0, 1'b1);
        check_eq("t5_stray_err", 32'(bus_err_o), 32'd1);
        check_eq("t5_stray_drained", 32'(drained_o), 32'd1);
        step(1'b1, 32'h0000_5004, 32'h0000_0077, 4'h1, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        check_eq("t5_stray_cnt0", 32'(drained_o), 32'd1);

        // Same-word stores while the request is back-pressured.
        step(1'b1, 32'h0000_2000, 32'h1122_3344, 4'h3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_2002, 32'hAABB_0000, 4'hC, 1'b0, 1'b0, 1'b0);
`ifdef SB_DRAIN_MERGE_EN
        check_eq("t6_merge_data", mem_req_data_o, 32'hAABB_3344);
        check_eq("t6_merge_strb", 32'(mem_req_strb_o), 32'hF);
`else
        check_eq("t6_first_data", mem_req_data_o, 32'h1122_3344);
        check_eq("t6_first_strb", 32'(mem_req_strb_o), 32'h3);
`endif
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        drain("t6_drained");

        // Random traffic over a few words to exercise merges, stalls and stray responses.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0,
                 32'h0000_3000 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)),
                 $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 2) != 0,
                 (m_out > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 63) == 0),
                 $urandom_range(0, 31) == 0);
        end
        drain("rand_drained");

        // Reset in the middle of traffic discards everything.
        step(1'b1, 32'h0000_6000, 32'h6666_6666, 4'hF, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h0000_6004, 32'h6666_7777, 4'hF, 1'b1, 1'b0, 1'b0);
        do_reset();
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sb_drain_unit.md
Name: sb_drain_unit

Overview:
- Consumer end of the store buffer's committed-entry handshake.
- Accepts committed stores one per handshake into a single hold register and issues them as memory write requests to the dcache/bus write port.
- Tracks outstanding write responses and reports when all stores have drained, for fence, ibar and uncached ordering.
- Committed stores are architecturally retired, so pipeline flush never affects this block.

Parameters:
ADDR_W, 32, store target address width
DATA_W, 32, write data width
MAX_OUTSTANDING, 2, maximum accepted-but-unresponded writes (>=1)
CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
sb_valid_i  in  1  store buffer offers committed entry
sb_ready_o  out  1  drain unit accepts entry
sb_addr_i  in  ADDR_W  entry target address
sb_data_i  in  DATA_W  entry write data
sb_strb_i  in  DATA_W/8  entry byte strobes
mem_req_valid_o  out  1  write request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  ADDR_W  write address, low 2 bits forced 0
mem_req_data_o  out  DATA_W  write data
mem_req_strb_o  out  DATA_W/8  write strobes
mem_resp_valid_i  in  1  write response valid
mem_resp_err_i  in  1  response carries bus error
mem_resp_ready_o  out  1  always 1 (responses never back-pressured)
drained_o  out  1  hold empty and no outstanding writes
bus_err_o  out  1  sticky error flag

Behaviour:
- Reset (async, rst=1): hold register empty, FSM=IDLE, out_cnt=0, bus_err_o=0, mem_req_valid_o=0, drained_o=1, sb_ready_o=1, data outputs 0.
- FSM states:
  - IDLE: hold empty.
  - ISSUE: hold valid, out_cnt<MAX_OUTSTANDING.
  - STALL: hold valid, out_cnt==MAX_OUTSTANDING.
  - State is a registered function of hold_valid and the next out_cnt, encoded explicitly.
- mem_req_valid_o = (state==ISSUE). Request fields come directly from hold registers (zero combinational input-to-request path).
- req_fire = mem_req_valid_o & mem_req_ready_i.
- resp_fire = mem_resp_valid_i (mem_resp_ready_o is always 1).
- sb_ready_o = !hold_valid | req_fire. Pass-through in the same cycle is allowed: a new entry loads into hold on the edge the old one is accepted.
- Once mem_req_valid_o is asserted, it and all request fields stay stable until req_fire.
- out_cnt next = out_cnt + req_fire - resp_fire:
  - Simultaneous req_fire and resp_fire leaves it unchanged.
  - A resp_fire at out_cnt==0 is a protocol error: ignore it (saturate at 0) and set bus_err_o.
- out_cnt never exceeds MAX_OUTSTANDING; ISSUE is never entered at the limit.
- A response arriving in STALL moves the FSM to ISSUE on the next cycle; the request may fire no earlier than that cycle.
- bus_err_o is set on resp_fire & mem_resp_err_i and cleared only by reset. The erroring store is not replayed; draining continues.
- drained_o = !hold_valid & (out_cnt==0), registered. It deasserts the cycle after any entry is accepted.
- Latency: an entry accepted at cycle N presents mem_req_valid_o at N+1 (if out_cnt permits).
- Ordering: strictly in acceptance order; no reordering.
- Reset mid-operation: hold contents and outstanding count are discarded immediately. The memory side must be reset in the same domain.

Optional Feature:
SB_DRAIN_MERGE_EN
- Defined: while hold is valid and not firing this cycle, an incoming entry with the same word address (addr[ADDR_W-1:2]) is merged into hold:
  - sb_ready_o=1 for that entry.
  - For each strb bit set, the corresponding hold data byte is overwritten.
  - hold strb |= new strb.
  - No additional request is issued.
  - Merging is forbidden in the cycle req_fire occurs (the entry loads as a new hold instead).
- Undefined: no merge logic; sb_ready_o = !hold_valid | req_fire only.

Test Plan:
- Reset then idle -> drained_o=1, sb_ready_o=1, mem_req_valid_o=0, bus_err_o=0.
- Single store addr=0x1000_0004, data=0xDEADBEEF, strb=0xF, mem_req_ready_i=1, response 3 cycles later -> request at cycle+1 with identical fields; drained_o returns to 1 the cycle after the response.
- MAX_OUTSTANDING=2, three back-to-back stores, responses withheld -> two requests fire, FSM=STALL, third held with mem_req_valid_o=0; release one response -> third request fires the following cycle.
- mem_req_ready_i=0 for 5 cycles with hold valid -> sb_ready_o=0, request fields stable, no entry lost; ready=1 -> pass-through accept of the next entry in the same cycle.
- Response with mem_resp_err_i=1 -> bus_err_o=1 persists; a stray response at out_cnt=0 also sets bus_err_o and leaves out_cnt=0.
- SB_DRAIN_MERGE_EN, mem_req_ready_i=0: store 0x2000 data=0x11223344 strb=0x3, then 0x2002 data=0xAABB0000 strb=0xC -> single request data=0xAABB3344 strb=0xF; without the macro -> two requests in order.
